// File: rtl/traffic_sensor_cond_if.sv
// traffic_sensor_cond_if
//   Groups the sensor-side inputs and the conditioned outputs of one
//   traffic_sensor_cond instance. clk and reset_n stay as plain ports.
//
//   Signals:
//     sen_a, sen_b         raw loop sensors (asynchronous to clk)
//     clr_cnt              synchronous clear of both arrival counters
//     ta, tb               registered "car present" per street
//     arrive_a, arrive_b   one-cycle pulse per accepted arrival
//     car_cnt_a, car_cnt_b saturating arrival counts (CNT_W bits)
//
//   There is no handshake: inputs are plain levels and every output is
//   free-running, so there is no valid/ready pair and no back-pressure.
//
//   Modports:
//     master - drives sensors/clear, observes outputs (controller side / bench)
//     slave  - the conditioner itself
interface traffic_sensor_cond_if #(
    parameter int CNT_W = 8
);
    logic             sen_a;
    logic             sen_b;
    logic             clr_cnt;
    logic             ta;
    logic             tb;
    logic             arrive_a;
    logic             arrive_b;
    logic [CNT_W-1:0] car_cnt_a;
    logic [CNT_W-1:0] car_cnt_b;

    modport master (
        output sen_a, sen_b, clr_cnt,
        input  ta, tb, arrive_a, arrive_b, car_cnt_a, car_cnt_b
    );

    modport slave (
        input  sen_a, sen_b, clr_cnt,
        output ta, tb, arrive_a, arrive_b, car_cnt_a, car_cnt_b
    );
endinterface

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//   Conditions the two raw vehicle-loop sensors into the clean ta/tb inputs
//   of the traffic light controller. Per street: two-flop synchronizer,
//   debouncer, hold timer that stretches "car present" across short gaps,
//   and a saturating arrival counter. Channel 0 is street A, channel 1 is
//   street B; the two channels share nothing but clk/reset_n/clr_cnt.
//
//   Ports:
//     clk      in   clock
//     reset_n  in   asynchronous, active-low reset (clears every flop)
//     bus      slave modport of traffic_sensor_cond_if:
//                sen_a/sen_b in, clr_cnt in,
//                ta/tb, arrive_a/arrive_b, car_cnt_a/car_cnt_b out
//
//   Parameters:
//     DEB_CYCLES  consecutive synchronized cycles a new level must persist (>=1)
//     HOLD_CYCLES extra cycles ta/tb stay high after the debounced level falls
//     CNT_W       width of each arrival counter (must match the interface)
module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    traffic_sensor_cond_if.slave   bus
);
    localparam int DCNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    // A zero hold time still needs a legal one-bit register; it just never
    // leaves zero.
    localparam int HCNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_VAL = HCNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       sen_raw;
    logic [1:0]       tx_w;
    logic [1:0]       arr_w;
    logic [CNT_W-1:0] cnt_w [2];

    assign sen_raw = {bus.sen_b, bus.sen_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic              s1;
        logic              s2;
        logic              deb;
        logic              deb_prev;
        logic              deb_next;
        logic              rise;
        logic [DCNT_W-1:0] dcnt;
        logic [HCNT_W-1:0] hcnt;
        logic              tx;
        logic              arrive;
        logic [CNT_W-1:0]  cnt;

        // deb flips on the DEB_CYCLES-th consecutive edge on which the
        // synchronized level disagrees with it.
        always_comb begin
            deb_next = deb;
            if ((s2 != deb) && (dcnt == DEB_LAST)) begin
                deb_next = s2;
            end
        end

        // deb_prev lags deb by one edge, so this is high exactly on the edge
        // after deb went 0->1: the edge that raises tx and pulses arrive.
        assign rise = deb & ~deb_prev;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                deb      <= 1'b0;
                deb_prev <= 1'b0;
                dcnt     <= '0;
                hcnt     <= '0;
                tx       <= 1'b0;
                arrive   <= 1'b0;
                cnt      <= '0;
            end else begin
                s1 <= sen_raw[ch];
                s2 <= s1;

                // Any agreement restarts the persistence count.
                if (s2 == deb) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_LAST) begin
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DCNT_W'(1);
                end

                deb      <= deb_next;
                deb_prev <= deb;

                // A rise during the hold window kills the timer; tx stays
                // high through deb, so there is no gap.
                if (deb && !deb_next) begin
                    hcnt <= HOLD_VAL;
                end else if (!deb && deb_next) begin
                    hcnt <= '0;
                end else if (hcnt != '0) begin
                    hcnt <= hcnt - HCNT_W'(1);
                end

                tx     <= deb | (hcnt != '0);
                arrive <= rise;

                // Clear has priority over a coincident increment.
                if (bus.clr_cnt) begin
                    cnt <= '0;
                end else if (rise && (cnt != CNT_MAX)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign tx_w[ch]  = tx;
        assign arr_w[ch] = arrive;
        assign cnt_w[ch] = cnt;
    end

    assign bus.ta        = tx_w[0];
    assign bus.tb        = tx_w[1];
    assign bus.arrive_a  = arr_w[0];
    assign bus.arrive_b  = arr_w[1];
    assign bus.car_cnt_a = cnt_w[0];
    assign bus.car_cnt_b = cnt_w[1];
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond
//   Two instances share clk/reset_n and see identical sensor/clear stimulus:
//     u_dut0: DEB_CYCLES=4, HOLD_CYCLES=8, CNT_W=3
//     u_dut1: DEB_CYCLES=1, HOLD_CYCLES=0, CNT_W=8
//   A history-window reference model (channels 0/1 = dut0 A/B, 2/3 = dut1 A/B)
//   predicts every output each cycle; directed steps add fixed-latency checks.
module tb_traffic_sensor_cond;
    logic clk;
    logic reset_n;

    traffic_sensor_cond_if #(.CNT_W(3)) bus0 ();
    traffic_sensor_cond_if #(.CNT_W(8)) bus1 ();

    traffic_sensor_cond #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(8),
        .CNT_W      (3)
    ) u_dut0 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus0)
    );

    traffic_sensor_cond #(
        .DEB_CYCLES (1),
        .HOLD_CYCLES(0),
        .CNT_W      (8)
    ) u_dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int npulse;
    bit ra, rb;
    int hold_a, hold_b;

    // ---------------- reference model ----------------
    // sen_h[c][k]: sensor level sampled k edges ago (0 = this edge).
    // deb_h[c][k]: accepted level after the edge k edges ago.
    // The DUT sees the sensor two edges late; a level is accepted once the
    // last DEB synchronized samples all disagree with the accepted level.
    // tx is the OR of the accepted level over the last HOLD+1 edges, one
    // edge late; an arrival is a 0->1 of the accepted level, one edge late.
    bit sen_h [4][16];
    bit deb_h [4][16];
    bit m_tx  [4];
    bit m_arr [4];
    int m_cnt [4];

    function automatic int deb_of(input int c);
        return (c < 2) ? 4 : 1;
    endfunction

    function automatic int hold_of(input int c);
        return (c < 2) ? 8 : 0;
    endfunction

    function automatic int cmax_of(input int c);
        return (c < 2) ? 7 : 255;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 16; k++) begin
                sen_h[c][k] = 1'b0;
                deb_h[c][k] = 1'b0;
            end
            m_tx[c]  = 1'b0;
            m_arr[c] = 1'b0;
            m_cnt[c] = 0;
        end
    endtask

    task automatic model_edge(input int c, input bit sen, input bit clr);
        bit old_deb;
        bit all_diff;
        for (int k = 15; k > 0; k--) sen_h[c][k] = sen_h[c][k-1];
        sen_h[c][0] = sen;
        old_deb  = deb_h[c][0];
        all_diff = 1'b1;
        for (int k = 2; k <= deb_of(c) + 1; k++) begin
            if (sen_h[c][k] == old_deb) all_diff = 1'b0;
        end
        for (int k = 15; k > 0; k--) deb_h[c][k] = deb_h[c][k-1];
        deb_h[c][0] = all_diff ? !old_deb : old_deb;
        m_tx[c] = 1'b0;
        for (int k = 1; k <= hold_of(c) + 1; k++) m_tx[c] = m_tx[c] | deb_h[c][k];
        m_arr[c] = deb_h[c][1] & !deb_h[c][2];
        if (clr) m_cnt[c] = 0;
        else if (m_arr[c] && (m_cnt[c] < cmax_of(c))) m_cnt[c] = m_cnt[c] + 1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            model_edge(0, bus0.sen_a, bus0.clr_cnt);
            model_edge(1, bus0.sen_b, bus0.clr_cnt);
            model_edge(2, bus1.sen_a, bus1.clr_cnt);
            model_edge(3, bus1.sen_b, bus1.clr_cnt);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_ta",  8'(bus0.ta),        8'(m_tx[0]));
        chk("d0_tb",  8'(bus0.tb),        8'(m_tx[1]));
        chk("d0_arra", 8'(bus0.arrive_a), 8'(m_arr[0]));
        chk("d0_arrb", 8'(bus0.arrive_b), 8'(m_arr[1]));
        chk("d0_cnta", 8'(bus0.car_cnt_a), 8'(m_cnt[0]));
        chk("d0_cntb", 8'(bus0.car_cnt_b), 8'(m_cnt[1]));
        chk("d1_ta",  8'(bus1.ta),        8'(m_tx[2]));
        chk("d1_tb",  8'(bus1.tb),        8'(m_tx[3]));
        chk("d1_arra", 8'(bus1.arrive_a), 8'(m_arr[2]));
        chk("d1_arrb", 8'(bus1.arrive_b), 8'(m_arr[3]));
        chk("d1_cnta", 8'(bus1.car_cnt_a), 8'(m_cnt[2]));
        chk("d1_cntb", 8'(bus1.car_cnt_b), 8'(m_cnt[3]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_sen(input bit a, input bit b);
        bus0.sen_a = a;
        bus0.sen_b = b;
        bus1.sen_a = a;
        bus1.sen_b = b;
    endtask

    task automatic set_clr(input bit c);
        bus0.clr_cnt = c;
        bus1.clr_cnt = c;
    endtask

    // One clock: wait for the falling edge after the next rising edge and
    // compare every output against the model.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_n = 1'b0;
        set_sen(1'b0, 1'b0);
        set_clr(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_ta",   8'(bus0.ta),        8'd0);
        chk("rst_tb",   8'(bus0.tb),        8'd0);
        chk("rst_arra", 8'(bus0.arrive_a),  8'd0);
        chk("rst_cnta", 8'(bus0.car_cnt_a), 8'd0);
        check_all();
        reset_n = 1'b1;
        ticks(1);
        chk("rel_ta", 8'(bus0.ta), 8'd0);

        // Clean arrival on A: ta and arrive_a at edge 6.
        set_sen(1'b1, 1'b0);
        ticks(6);
        chk("a_rise_e5", 8'(bus0.ta), 8'd0);
        ticks(1);
        chk("a_rise_e6_ta",  8'(bus0.ta),        8'd1);
        chk("a_rise_e6_arr", 8'(bus0.arrive_a),  8'd1);
        chk("a_rise_cnt",    8'(bus0.car_cnt_a), 8'd1);
        chk("a_rise_tb",     8'(bus0.tb),        8'd0);
        chk("a_rise_cntb",   8'(bus0.car_cnt_b), 8'd0);
        ticks(1);
        chk("a_arr_one_cycle", 8'(bus0.arrive_a), 8'd0);

        // Glitch on B: 3 cycles high.
        set_sen(1'b1, 1'b1);
        ticks(3);
        set_sen(1'b1, 1'b0);
        ticks(12);
        chk("b_glitch_tb",  8'(bus0.tb),        8'd0);
        chk("b_glitch_cnt", 8'(bus0.car_cnt_b), 8'd0);

        // 3-cycle dropout on A while ta high.
        set_sen(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            chk("a_drop_ta", 8'(bus0.ta), 8'd1);
        end
        set_sen(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            chk("a_drop_ta", 8'(bus0.ta), 8'd1);
        end
        chk("a_drop_cnt", 8'(bus0.car_cnt_a), 8'd1);

        // Fall with hold: ta falls at edge 14.
        set_sen(1'b0, 1'b0);
        ticks(14);
        chk("a_fall_e13", 8'(bus0.ta), 8'd1);
        ticks(1);
        chk("a_fall_e14", 8'(bus0.ta), 8'd0);
        set_sen(1'b1, 1'b0);
        ticks(20);
        chk("a_rearm_cnt", 8'(bus0.car_cnt_a), 8'd2);

        // Re-arrival 6 cycles after the fall: no gap, one pulse.
        npulse = 0;
        set_sen(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ticks(1);
            chk("a_rearr_ta", 8'(bus0.ta), 8'd1);
            if (bus0.arrive_a) npulse++;
        end
        set_sen(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            ticks(1);
            chk("a_rearr_ta", 8'(bus0.ta), 8'd1);
            if (bus0.arrive_a) npulse++;
        end
        chk("a_rearr_pulses", 8'(npulse),          8'd1);
        chk("a_rearr_cnt",    8'(bus0.car_cnt_a), 8'd3);

        // Saturation on B (CNT_W=3): 9 arrivals stop at 7.
        for (int i = 0; i < 9; i++) begin
            set_sen(1'b1, 1'b1);
            ticks(10);
            set_sen(1'b1, 1'b0);
            ticks(12);
        end
        chk("b_sat_cnt", 8'(bus0.car_cnt_b), 8'd7);

        // 10th arrival with coincident clear: clear wins, pulse still seen.
        set_sen(1'b1, 1'b1);
        ticks(6);
        set_clr(1'b1);
        ticks(1);
        set_clr(1'b0);
        chk("b_clr_arr", 8'(bus0.arrive_b),  8'd1);
        chk("b_clr_cnt", 8'(bus0.car_cnt_b), 8'd0);

        // Async reset with A mid-debounce and B mid-hold.
        set_sen(1'b0, 1'b1);
        ticks(30);
        set_sen(1'b0, 1'b0);
        ticks(7);
        set_sen(1'b1, 1'b0);
        ticks(3);
        chk("pre_rst_tb", 8'(bus0.tb), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ta", 8'(bus0.ta), 8'd0);
        chk("mid_rst_tb", 8'(bus0.tb), 8'd0);
        check_all();
        @(negedge clk);
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        ticks(6);
        chk("post_rst_e5", 8'(bus0.ta), 8'd0);
        ticks(1);
        chk("post_rst_e6_ta",  8'(bus0.ta),       8'd1);
        chk("post_rst_e6_arr", 8'(bus0.arrive_a), 8'd1);

        // Simultaneous rise on both channels; dut1 is the short corner.
        set_sen(1'b0, 1'b0);
        ticks(30);
        set_sen(1'b1, 1'b1);
        ticks(3);
        chk("d1_sim_e2_ta", 8'(bus1.ta), 8'd0);
        ticks(1);
        chk("d1_sim_e3_ta",   8'(bus1.ta),       8'd1);
        chk("d1_sim_e3_tb",   8'(bus1.tb),       8'd1);
        chk("d1_sim_e3_arra", 8'(bus1.arrive_a), 8'd1);
        chk("d1_sim_e3_arrb", 8'(bus1.arrive_b), 8'd1);
        ticks(2);
        chk("d0_sim_e5_ta", 8'(bus0.ta), 8'd0);
        ticks(1);
        chk("d0_sim_e6_ta",   8'(bus0.ta),       8'd1);
        chk("d0_sim_e6_tb",   8'(bus0.tb),       8'd1);
        chk("d0_sim_e6_arra", 8'(bus0.arrive_a), 8'd1);
        chk("d0_sim_e6_arrb", 8'(bus0.arrive_b), 8'd1);
        ticks(10);
        set_sen(1'b0, 1'b0);
        ticks(3);
        chk("d1_fall_e2_ta", 8'(bus1.ta), 8'd1);
        ticks(1);
        chk("d1_fall_e3_ta", 8'(bus1.ta), 8'd0);
        chk("d1_fall_e3_tb", 8'(bus1.tb), 8'd0);
        ticks(20);

        // Randomized sensor activity with occasional clears.
        ra = 1'b0;
        rb = 1'b0;
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_a == 0) begin
                ra = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 12);
            end
            if (hold_b == 0) begin
                rb = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 12);
            end
            hold_a--;
            hold_b--;
            set_sen(ra, rb);
            set_clr($urandom_range(0, 39) == 0);
            ticks(1);
        end
        set_clr(1'b0);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
